bpsk_modulator: RTL and testbench

- Transmit-side counterpart of bpsk_demodulator_top.
- Accepts a bit stream over a valid/ready handshake and drives a free-running NCO phase into a shared cosine_lut read port.
- Emits signed fixed-point BPSK samples: carrier for bit 0, negated carrier for bit 1, with a configurable all-zero preamble so the demodulator loop can lock.
- Sits between the bit source (framer/UART bridge) and the DAC/sample sink at SAMPLING_FREQ.

---
 rtl/bpsk_modulator_if.sv | 25 ++
 rtl/bpsk_modulator.sv | 167 ++++++++++++++++
 tb/tb_bpsk_modulator.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bpsk_modulator_if.sv
// Bit-source handshake into the BPSK modulator: tx_en request plus bit valid/ready.
// Latency: none (wires only).
// Backpressure: bit_ready low while the modulator's holding register is occupied.
interface bpsk_modulator_if;
  logic tx_en;
  logic bit_in;
  logic bit_valid;
  logic bit_ready;

  // Bit source side (framer / UART bridge)
  modport master (
    output tx_en,
    output bit_in,
    output bit_valid,
    input  bit_ready
  );

  // Modulator side
  modport slave (
    input  tx_en,
    input  bit_in,
    input  bit_valid,
    output bit_ready
  );
endinterface

// File: rtl/bpsk_modulator.sv
// BPSK modulator: free-running NCO into an external cosine LUT, sign flipped per symbol bit.
// Latency: 2 cycles from phase issue on cos_lu_angle_steps to the matching data_out sample.
// Backpressure: one-entry holding register; bit_ready drops until the next DATA symbol drains it.
module bpsk_modulator #(
  parameter int DATA_WIDTH         = 24,
  parameter int PHASE_WIDTH        = 6,
  parameter int PHASE_STEP         = 4,
  parameter int INITIAL_PHASE      = 0,
  parameter int SAMPLES_PER_SYMBOL = 16,
  parameter int PREAMBLE_SYMBOLS   = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  bpsk_modulator_if.slave              bus,
  output logic [PHASE_WIDTH-1:0]       cos_lu_angle_steps,
  input  logic signed [DATA_WIDTH-1:0] cos_lu_value,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         data_out_active,
  output logic                         symbol_strobe,
  output logic                         underrun
);

  localparam int SCW = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
  localparam int PCW = (PREAMBLE_SYMBOLS > 1) ? $clog2(PREAMBLE_SYMBOLS) : 1;
  localparam logic [SCW-1:0] SYM_LAST = SCW'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [PCW-1:0] PRE_LAST = PCW'((PREAMBLE_SYMBOLS > 0) ? PREAMBLE_SYMBOLS - 1 : 0);
  localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PCW-1:0]   pre_cnt_q, pre_cnt_d;
  logic [SCW-1:0]   sym_cnt;
  logic             boundary;
  logic             cur_bit_q, cur_bit_d;
  logic             cur_under_q, cur_under_d;
  logic             load_data;
  logic             drain;
  logic             hold_full;
  logic             hold_bit;
  logic             accept;

  // Stage-0 attributes belong to the sample whose phase is on cos_lu_angle_steps now
  logic             act0, stb0, und0;
  logic             act1, bit1, stb1, und1;
  logic signed [DATA_WIDTH-1:0] neg_val;

  assign boundary      = (sym_cnt == SYM_LAST);
  assign accept        = bus.bit_valid && !hold_full;
  assign bus.bit_ready = ~hold_full;

  assign act0 = (state_q != IDLE);
  assign stb0 = (sym_cnt == '0);
  assign und0 = cur_under_q && (sym_cnt == '0);

  // Negation clamps the most negative code so the inverted carrier never wraps
  assign neg_val = (cos_lu_value == S_MIN) ? S_MAX : -cos_lu_value;

  // NCO and symbol counter run continuously, independent of the FSM, to keep the carrier coherent
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cos_lu_angle_steps <= PHASE_WIDTH'(INITIAL_PHASE);
      sym_cnt            <= '0;
    end else begin
      cos_lu_angle_steps <= cos_lu_angle_steps + PHASE_WIDTH'(PHASE_STEP);
      sym_cnt            <= boundary ? '0 : sym_cnt + SCW'(1);
    end
  end

  // Symbol sequencing: decide the next symbol's kind and bit only at the last sample of a symbol
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    cur_bit_d   = cur_bit_q;
    cur_under_d = cur_under_q;
    load_data   = 1'b0;
    drain       = 1'b0;
    if (boundary) begin
      cur_bit_d   = 1'b0;
      cur_under_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.tx_en) begin
            pre_cnt_d = '0;
            if (PREAMBLE_SYMBOLS == 0) load_data = 1'b1;
            else                       state_d   = PREAMBLE;
          end
        end
        PREAMBLE: begin
          if (pre_cnt_q == PRE_LAST) load_data = 1'b1;
          else                       pre_cnt_d = pre_cnt_q + PCW'(1);
        end
        DATA: begin
          if (!bus.tx_en) state_d   = IDLE;
          else            load_data = 1'b1;
        end
        default: state_d = IDLE;
      endcase
      if (load_data) begin
        state_d = DATA;
        if (hold_full) begin
          cur_bit_d = hold_bit;
          drain     = 1'b1;
        end else begin
          cur_under_d = 1'b1;
        end
      end
    end
  end

  // FSM state and current-symbol registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pre_cnt_q   <= '0;
      cur_bit_q   <= 1'b0;
      cur_under_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      cur_bit_q   <= cur_bit_d;
      cur_under_q <= cur_under_d;
    end
  end

  // One-entry holding register; it keeps its bit across IDLE so it goes out first on the next DATA entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_bit  <= 1'b0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_bit  <= bus.bit_in;
    end else if (drain) begin
      hold_full <= 1'b0;
    end
  end

  // Two-stage alignment: stage 1 waits for the LUT read, stage 2 registers the signed sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act1            <= 1'b0;
      bit1            <= 1'b0;
      stb1            <= 1'b0;
      und1            <= 1'b0;
      data_out        <= '0;
      data_out_active <= 1'b0;
      symbol_strobe   <= 1'b0;
      underrun        <= 1'b0;
    end else begin
      act1            <= act0;
      bit1            <= cur_bit_q;
      stb1            <= stb0;
      und1            <= und0;
      data_out        <= act1 ? (bit1 ? neg_val : cos_lu_value) : '0;
      data_out_active <= act1;
      symbol_strobe   <= stb1;
      underrun        <= und1;
    end
  end

endmodule

// File: tb/tb_bpsk_modulator.sv
// Bench for bpsk_modulator: symbol-level reference model checked every cycle,
// plus literal expectations at fixed cycles of a directed run and a randomized run.
module tb_bpsk_modulator;

  localparam int DW   = 24;
  localparam int PW   = 6;
  localparam int STEP = 5;
  localparam int INIT = 7;
  localparam int SPS  = 8;
  localparam int PRE  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] cos_lu_angle_steps;
  logic [DW-1:0] cos_lu_value;
  logic [DW-1:0] data_out;
  logic          data_out_active;
  logic          symbol_strobe;
  logic          underrun;

  bpsk_modulator_if bif();

  bpsk_modulator #(
    .DATA_WIDTH(DW), .PHASE_WIDTH(PW), .PHASE_STEP(STEP), .INITIAL_PHASE(INIT),
    .SAMPLES_PER_SYMBOL(SPS), .PREAMBLE_SYMBOLS(PRE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif),
    .cos_lu_angle_steps(cos_lu_angle_steps), .cos_lu_value(cos_lu_value),
    .data_out(data_out), .data_out_active(data_out_active),
    .symbol_strobe(symbol_strobe), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Stand-in LUT with 1-cycle read latency: a linear ramp whose entry 0 is the most negative code
  always @(posedge clk) cos_lu_value <= DW'((int'(cos_lu_angle_steps) - 32) * 262144);

  int n_cmp  = 0;
  int n_fail = 0;
  int n      = 0;
  bit started     = 0;
  bit rst_sampled = 0;
  bit lit_mode    = 0;

  always @(posedge clk) begin
    started     <= 1'b1;
    rst_sampled <= !rst_n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  // Reference model state: per-symbol plan and the queue of accepted-but-unsent bits
  typedef struct {
    bit      active;
    bit      b;
    bit      strobe;
    bit      under;
    int      idx;
  } rec_t;

  rec_t hist[$];
  bit   m_hold[$];
  int   m_mode;      // 0 silent, 1 preamble, 2 data
  int   m_pre_sent;
  bit   m_active, m_bit, m_under;

  function automatic int model_sample(input rec_t r);
    int v;
    v = (r.idx - 32) * 262144;
    if (!r.active) return 0;
    if (r.b) v = (v == -(1 << (DW - 1))) ? ((1 << (DW - 1)) - 1) : -v;
    return v;
  endfunction

  task automatic start_data();
    m_mode   = 2;
    m_active = 1;
    if (m_hold.size() > 0) begin
      m_bit = m_hold.pop_front();
    end else begin
      m_bit   = 0;
      m_under = 1;
    end
  endtask

  always @(negedge clk) begin
    int   ph;
    bit   acc;
    rec_t r;
    rec_t cur;
    logic [DW-1:0] exp_d;
    if (started) begin
      if (rst_sampled) begin
        n = 0;
        hist.delete();
        m_hold.delete();
        m_mode = 0; m_pre_sent = 0;
        m_active = 0; m_bit = 0; m_under = 0;
      end
      ph = (INIT + n * STEP) % (1 << PW);
      check("phase", 32'(cos_lu_angle_steps), 32'(ph));
      check("bit_ready", 32'(bif.bit_ready), 32'(m_hold.size() == 0));

      cur.active = m_active;
      cur.b      = m_bit;
      cur.strobe = (n % SPS == 0);
      cur.under  = m_under && (n % SPS == 0);
      cur.idx    = ph;
      hist.push_back(cur);
      if (hist.size() == 3) begin
        r = hist.pop_front();
      end else begin
        r = '{active: 0, b: 0, strobe: 0, under: 0, idx: 32};
      end
      exp_d = DW'(model_sample(r));
      check("data_out", 32'(data_out), 32'(exp_d));
      check("active", 32'(data_out_active), 32'(r.active));
      check("strobe", 32'(symbol_strobe), 32'(r.strobe));
      check("underrun", 32'(underrun), 32'(r.under));

      if (lit_mode) begin
        if (n == 0)   check("lit_phase0", 32'(cos_lu_angle_steps), 32'h07);
        if (n == 12)  check("lit_wrap", 32'(cos_lu_angle_steps), 32'h03);
        if (n == 9)   check("lit_idle", {7'h0, data_out_active, data_out}, 32'h0);
        if (n == 10)  check("lit_first_pre", {6'h0, symbol_strobe, data_out_active, data_out}, 32'h033C0000);
        if (n == 39)  check("lit_pre_min", 32'(data_out), 32'h800000);
        if (n == 103) check("lit_sat", {7'h0, data_out_active, data_out}, 32'h17FFFFF);
      end

      acc = bif.bit_valid && (m_hold.size() == 0);
      if (n % SPS == SPS - 1) begin
        m_under = 0;
        m_bit   = 0;
        case (m_mode)
          0: begin
            if (bif.tx_en) begin
              if (PRE > 0) begin m_mode = 1; m_pre_sent = 1; m_active = 1; end
              else start_data();
            end
          end
          1: begin
            if (m_pre_sent == PRE) start_data();
            else m_pre_sent++;
          end
          default: begin
            if (!bif.tx_en) begin m_mode = 0; m_active = 0; end
            else start_data();
          end
        endcase
      end
      if (acc) m_hold.push_back(bif.bit_in);
      n++;
    end
  end

  initial begin
    rst_n = 1'b0;
    bif.tx_en = 1'b0; bif.bit_valid = 1'b0; bif.bit_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Long idle: silent output, NCO wrapping many times
    repeat (1000) @(posedge clk);

    // Directed: reset, then preamble followed by a steady stream of 1s
    #1;
    rst_n = 1'b0; lit_mode = 1'b1;
    bif.tx_en = 1'b1; bif.bit_valid = 1'b1; bif.bit_in = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (130) @(posedge clk);
    #1 lit_mode = 1'b0;

    // Randomized: tx_en toggling, bursty bits, underrun-heavy second half, reset mid-stream
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 199) == 0) bif.tx_en = !bif.tx_en;
      bif.bit_valid = ($urandom_range(0, 99) < ((c < 2000) ? 85 : 30));
      bif.bit_in    = 1'($urandom_range(0, 1));
      rst_n         = !(c == 1500 || c == 1501);
    end
    bif.tx_en = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
